affine_interp_ctrl: RTL
=======================

# affine_interp_ctrl

Sequencer for the separable affine luma interpolation datapath. Per 4x4 sub-block it latches the 1/16-sample fractional phase, streams reference rows from the synchronous reference buffer through the horizontal MCM coefficient bank into the external vertical row window, and releases one filtered output row per window position under a valid/ready handshake. It sits between the affine motion-vector stage, which issues `start`, and the sample write-back stage, which consumes output rows.

## Interface
- `BLK_H`, 4, output rows per block (2..8)
- `TAPS`, 8, filter taps (even); fetched rows NR = BLK_H+TAPS-1 (11 by default)
- `RW`, $clog2(BLK_H+TAPS-1), width of `ref_row`
- `OW`, $clog2(BLK_H), width of `out_row`

- `clk` in 1 — single clock, rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `start` in 1 — block request; accepted only when `ready`=1
- `frac_x` in 4 — horizontal phase, sampled on accept
- `frac_y` in 4 — vertical phase, sampled on accept
- `ready` out 1 — able to accept `start`
- `ref_rd_en` out 1 — reference buffer read strobe; buffer data holds while low
- `ref_row` out RW — row index for the read
- `h_phase` out 4 — horizontal coefficient-set select (latched `frac_x`)
- `v_phase` out 4 — vertical coefficient-set select (latched `frac_y`)
- `v_shift_en` out 1 — shift the current horizontally filtered row into the vertical window
- `v_valid` out 1 — vertical filter output row valid
- `out_ready` in 1 — consumer accepts the row when `v_valid` & `out_ready`
- `out_row` out OW — index of the presented output row
- `done` out 1 — one-cycle pulse after the block's last row is accepted

## Operation
- FSM: IDLE -> FETCH on `start`&`ready`; FETCH -> DONE on the shift of the final row; DONE -> IDLE, or DONE -> FETCH if `start` is asserted in DONE.
- `ready`=1 in IDLE and DONE, 0 in FETCH. `start` while `ready`=0 is ignored.
- On accept: `h_phase`<=`frac_x`, `v_phase`<=`frac_y`, row counter <= first row (0), data-valid flag `dv`<=0.
- FETCH: `ref_rd_en` = rows_remaining & (!`dv` | `v_shift_en`); the row counter increments on each read. `dv` is set the cycle after a read and cleared when the row shifts without a new read.
- Row r in the datapath (`dv`=1): for r < TAPS-1 it is a priming row, so `v_shift_en`=1 and `v_valid`=0. For r >= TAPS-1, `v_valid`=1, `out_row`=r-(TAPS-1), and `v_shift_en`=`out_ready`.
- Stall: while `v_valid`&!`out_ready`, `v_shift_en`=0 and `ref_rd_en`=0. The buffer holds its data, and no row is lost or duplicated.
- The vertical filter is combinational on {window[1..TAPS-1], current row}, so the output row is valid in the same cycle as its shift.

## Timing
- Reset values: `ready`=1, all other outputs 0, FSM IDLE, counters 0. Reset mid-block aborts immediately with no `done`; the next `start` runs a clean block.
- With defaults and `out_ready` held at 1, `start` is sampled at cycle 0:
  - `ref_rd_en` is asserted at cycles 1..11 with `ref_row` 0..10.
  - `v_valid` is asserted at cycles 9..12 with `out_row` 0..3.
  - `done` is asserted at cycle 13.
- Each cycle of `out_ready`=0 while `v_valid`=1 adds exactly one cycle to the latency.
- `h_phase` and `v_phase` are stable from cycle 1 until the next accept.

## Configuration
- `AFFINE_BYPASS_EN` defined: when latched `frac_y`==0, only rows TAPS/2-1 .. TAPS/2-2+BLK_H are fetched (3..6 by default).
  - Every one of these rows is an output row: `v_valid` is asserted with `out_row` 0..BLK_H-1, and `v_phase`=0.
  - Default-parameter latency is `done` at cycle 6.
- Undefined: all NR rows are always fetched. Phase 0 uses the identity coefficient set, so the output samples are identical to the bypass case; only the latency differs.

## Test plan
- Reset mid-block: `rst_n` low at cycle 5 -> all outputs 0 and `ready`=1 immediately, no `done`; a following `start` gives `ref_row` 0..10.
- Nominal block: `frac_x`=5, `frac_y`=9, `out_ready`=1 -> reads at cycles 1..11, `out_row` 0..3 at cycles 9..12, `done` at 13, `h_phase`=5, `v_phase`=9.
- Backpressure: `out_ready`=0 during cycles 9..11 -> `ref_rd_en` and `v_shift_en` low throughout, `out_row`=0 held, `done` at cycle 16, no row duplicated.
- Back-to-back blocks: `start` asserted in the DONE cycle -> second block's `ref_row`=0 on the next cycle; `start` asserted during FETCH is ignored.
- Bypass: `frac_y`=0 with `AFFINE_BYPASS_EN` -> reads of `ref_row` 3..6 at cycles 1..4, `v_valid` at 2..5, `done` at 6; without the macro -> the nominal 11-row timing.

Source files
------------

// File: rtl/affine_interp_ctrl.sv
// Row sequencer for the separable affine luma interpolation datapath.
// Optional phase-0 row-skipping feature is enabled by defining AFFINE_BYPASS_EN.
module affine_interp_ctrl #(
  parameter int BLK_H = 4,
  parameter int TAPS  = 8,
  parameter int RW    = $clog2(BLK_H + TAPS - 1),
  parameter int OW    = $clog2(BLK_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [3:0]    frac_x_i,
  input  logic [3:0]    frac_y_i,
  output logic          ready_o,
  output logic          ref_rd_en_o,
  output logic [RW-1:0] ref_row_o,
  output logic [3:0]    h_phase_o,
  output logic [3:0]    v_phase_o,
  output logic          v_shift_en_o,
  output logic          v_valid_o,
  input  logic          out_ready_i,
  output logic [OW-1:0] out_row_o,
  output logic          done_o
);

  localparam int NR = BLK_H + TAPS - 1;
  // One spare bit so the read counter can step past the last row index.
  localparam int CW = RW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [CW-1:0] ROW_ZERO  = CW'(0);
  localparam logic [CW-1:0] FIRST_BYP = CW'(TAPS / 2 - 1);
  localparam logic [CW-1:0] LAST_BYP  = CW'(TAPS / 2 - 2 + BLK_H);
  localparam logic [CW-1:0] LAST_FULL = CW'(NR - 1);
  localparam logic [CW-1:0] PRIME     = CW'(TAPS - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CW-1:0] last_q, last_d;
  logic [CW-1:0] cur_row_q, cur_row_d;
  logic          dv_q, dv_d;
  logic          byp_q, byp_d;
  logic [3:0]    h_q, h_d;
  logic [3:0]    v_q, v_d;

  logic          fetch_s, accept_s, rows_rem_s, valid_s, shift_s, rd_s, byp_sel_s;
  logic [CW-1:0] orow_s;

`ifdef AFFINE_BYPASS_EN
  assign byp_sel_s = (frac_y_i == 4'd0);
`else
  assign byp_sel_s = 1'b0;
`endif

  assign fetch_s    = (state_q == S_FETCH);
  assign accept_s   = start_i & (state_q != S_FETCH);
  assign rows_rem_s = fetch_s & (rd_cnt_q <= last_q);
  // In bypass every fetched row is an output row; otherwise the first TAPS-1 only prime the window.
  assign valid_s    = fetch_s & dv_q & (byp_q | (cur_row_q >= PRIME));
  assign shift_s    = fetch_s & dv_q & (valid_s ? out_ready_i : 1'b1);
  assign rd_s       = rows_rem_s & (~dv_q | shift_s);
  assign orow_s     = cur_row_q - (byp_q ? FIRST_BYP : PRIME);

  assign ready_o      = (state_q != S_FETCH);
  assign ref_rd_en_o  = rd_s;
  assign ref_row_o    = rd_s ? rd_cnt_q[RW-1:0] : {RW{1'b0}};
  assign h_phase_o    = h_q;
  assign v_phase_o    = v_q;
  assign v_shift_en_o = shift_s;
  assign v_valid_o    = valid_s;
  assign out_row_o    = valid_s ? orow_s[OW-1:0] : {OW{1'b0}};
  assign done_o       = (state_q == S_DONE);

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    last_d    = last_q;
    cur_row_d = cur_row_q;
    dv_d      = dv_q;
    byp_d     = byp_q;
    h_d       = h_q;
    v_d       = v_q;
    if (accept_s) begin
      state_d  = S_FETCH;
      h_d      = frac_x_i;
      v_d      = frac_y_i;
      byp_d    = byp_sel_s;
      rd_cnt_d = byp_sel_s ? FIRST_BYP : ROW_ZERO;
      last_d   = byp_sel_s ? LAST_BYP : LAST_FULL;
      dv_d     = 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (rd_s) begin
            rd_cnt_d  = rd_cnt_q + CW'(1);
            cur_row_d = rd_cnt_q;
            dv_d      = 1'b1;
          end else if (shift_s) begin
            dv_d = 1'b0;
          end else begin
            dv_d = dv_q;
          end
          // Final row leaves the datapath with nothing left to fetch.
          if (shift_s && !rows_rem_s) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_IDLE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rd_cnt_q  <= ROW_ZERO;
      last_q    <= ROW_ZERO;
      cur_row_q <= ROW_ZERO;
      dv_q      <= 1'b0;
      byp_q     <= 1'b0;
      h_q       <= 4'd0;
      v_q       <= 4'd0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      last_q    <= last_d;
      cur_row_q <= cur_row_d;
      dv_q      <= dv_d;
      byp_q     <= byp_d;
      h_q       <= h_d;
      v_q       <= v_d;
    end
  end

endmodule
